// File: rtl/bus_pkg.sv
// Shared bus widths, response encoding and the slave FSM state type.
package bus_pkg;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} slv_state_t;
endpackage

// File: rtl/bus_mem_slave.sv
// Memory-backed single-beat bus responder owning [BASE_ADDR, BASE_ADDR+ADDR_SPAN).
// Outputs are registered and held at zero except for the one-cycle response.
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h00,
  parameter int unsigned       ADDR_SPAN   = 64,
  parameter int unsigned       MEM_DEPTH   = 64,
  parameter int unsigned       WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              resp
);
  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  slv_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_q, resp_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic              sel;
  logic [ADDR_W-1:0] offset;
  logic              fire;
  logic              req_wr;
  logic [ADDR_W-1:0] req_off;
  logic [DATA_W-1:0] req_wdat;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              mem_we;

  // 9-bit compare so the top window end (0xC0+64) does not wrap to zero.
  assign sel    = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, addr} <  ({1'b0, BASE_ADDR} + 9'(ADDR_SPAN)));
  assign offset = addr - BASE_ADDR;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    off_d    = off_q;
    wdat_d   = wdat_q;
    fire     = 1'b0;
    req_wr   = wr_q;
    req_off  = off_q;
    req_wdat = wdat_q;
    unique case (state_q)
      S_IDLE: if (valid && sel) begin
        wr_d     = wr_en;
        off_d    = offset;
        wdat_d   = wdata;
        // With no wait states the response is built straight from the bus.
        req_wr   = wr_en;
        req_off  = offset;
        req_wdat = wdata;
        if (WS == 4'd0) begin
          state_d = S_RESP;
          fire    = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = WS - 4'd1;
        end
      end
      S_WAIT: begin
        if (!valid) state_d = S_IDLE;
        else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          fire    = 1'b1;
        end else cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_range = 32'(req_off) < MEM_DEPTH;
    idx      = IDX_W'(req_off);
    mem_we   = fire && req_wr && in_range;
    ready_d  = fire;
    resp_d   = fire && !in_range ? RESP_ERR : RESP_OKAY;
    rdata_d  = (fire && !req_wr && in_range) ? mem_q[idx] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      off_q   <= '0;
      wdat_q  <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[idx] <= req_wdat;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;
  assign resp  = resp_q;
endmodule

// File: tb/tb_bus_mem_slave.sv
// Bench for bus_mem_slave: three independent buses (dual-slave W=2, depth-32 W=3, W=0)
// checked against a flat per-bus address-map model.
module tb_bus_mem_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld [3];
  logic        we  [3];
  logic [7:0]  ad  [3];
  logic [31:0] wd  [3];
  logic        rdy [3];
  logic [31:0] rd  [3];
  logic        rs  [3];

  logic        rdyA0, rdyA1, rsA0, rsA1, rdyB, rsB, rdyC, rsC;
  logic [31:0] rdA0, rdA1, rdB, rdC;

  bus_mem_slave #(.BASE_ADDR(8'h00), .ADDR_SPAN(64), .MEM_DEPTH(64), .WAIT_STATES(2)) dA0 (
    .clk(clk), .rst_n(rst_n), .valid(vld[0]), .wr_en(we[0]), .addr(ad[0]), .wdata(wd[0]),
    .ready(rdyA0), .rdata(rdA0), .resp(rsA0));
  bus_mem_slave #(.BASE_ADDR(8'h40), .ADDR_SPAN(64), .MEM_DEPTH(64), .WAIT_STATES(2)) dA1 (
    .clk(clk), .rst_n(rst_n), .valid(vld[0]), .wr_en(we[0]), .addr(ad[0]), .wdata(wd[0]),
    .ready(rdyA1), .rdata(rdA1), .resp(rsA1));
  bus_mem_slave #(.BASE_ADDR(8'h00), .ADDR_SPAN(64), .MEM_DEPTH(32), .WAIT_STATES(3)) dB (
    .clk(clk), .rst_n(rst_n), .valid(vld[1]), .wr_en(we[1]), .addr(ad[1]), .wdata(wd[1]),
    .ready(rdyB), .rdata(rdB), .resp(rsB));
  bus_mem_slave #(.BASE_ADDR(8'h00), .ADDR_SPAN(64), .MEM_DEPTH(64), .WAIT_STATES(0)) dC (
    .clk(clk), .rst_n(rst_n), .valid(vld[2]), .wr_en(we[2]), .addr(ad[2]), .wdata(wd[2]),
    .ready(rdyC), .rdata(rdC), .resp(rsC));

  assign rdy[0] = rdyA0 | rdyA1;
  assign rd[0]  = rdA0 | rdA1;
  assign rs[0]  = rsA0 | rsA1;
  assign rdy[1] = rdyB;
  assign rd[1]  = rdB;
  assign rs[1]  = rsB;
  assign rdy[2] = rdyC;
  assign rd[2]  = rdC;
  assign rs[2]  = rsC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flat model: one 256-entry array per bus, indexed by bus address.
  logic [31:0] mm [3][256];

  function automatic int wl(input int b);
    return (b == 0) ? 2 : (b == 1) ? 3 : 0;
  endfunction
  function automatic bit model_err(input int b, input logic [7:0] a);
    return (b == 1) && (a >= 8'd32);
  endfunction
  function automatic logic [31:0] model_rd(input int b, input bit w, input logic [7:0] a);
    return (w || model_err(b, a)) ? 32'h0 : mm[b][a];
  endfunction
  function automatic void model_apply(input int b, input bit w, input logic [7:0] a,
                                      input logic [31:0] d);
    if (w && !model_err(b, a)) mm[b][a] = d;
  endfunction
  function automatic void model_clear();
    for (int b = 0; b < 3; b++) for (int i = 0; i < 256; i++) mm[b][i] = 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // For bus 0, the slave not owning the address must stay fully quiet.
  function automatic bit other_quiet(input logic [7:0] a);
    if (a >= 8'h40) return !rdyA0 && rdA0 == 32'h0 && !rsA0;
    return !rdyA1 && rdA1 == 32'h0 && !rsA1;
  endfunction

  task automatic xact(input int b, input bit w, input logic [7:0] a, input logic [31:0] d,
                      input bit hold, output logic [31:0] ord, output logic ors, output int lat);
    bit quiet;
    bit seen;
    quiet = 1'b1;
    seen  = 1'b0;
    lat   = 0;
    @(negedge clk);
    vld[b] = 1'b1; we[b] = w; ad[b] = a; wd[b] = d;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (b == 0 && !other_quiet(a)) quiet = 1'b0;
      if (rdy[b]) seen = 1'b1;
    end
    ord = rd[b];
    ors = rs[b];
    rdy_cyc = cyc;
    chk($sformatf("ready_seen b%0d a%h", b, a), 32'(seen), 32'd1);
    if (!hold) begin
      @(negedge clk);
      vld[b] = 1'b0;
    end
    @(posedge clk); #1;
    chk($sformatf("ready_one_cycle b%0d", b), 32'(rdy[b]), 32'd0);
    chk($sformatf("idle_rdata_zero b%0d", b), rd[b], 32'h0);
    if (b == 0) begin
      if (!other_quiet(a)) quiet = 1'b0;
      chk($sformatf("unsel_quiet a%h", a), 32'(quiet), 32'd1);
    end
  endtask

  typedef struct {
    int          b;
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] erd;
    logic        ers;
  } vec_t;
  vec_t tbl [12];

  logic [31:0] ord;
  logic        ors;
  int          lat;
  int          c1;
  bit          ok;

  initial begin
    tbl[0]  = '{0, 1'b1, 8'h10, 32'hAAAA_BBBB, 32'h0,         1'b0};
    tbl[1]  = '{0, 1'b0, 8'h10, 32'h0,         32'hAAAA_BBBB, 1'b0};
    tbl[2]  = '{0, 1'b1, 8'h50, 32'hCCCC_DDDD, 32'h0,         1'b0};
    tbl[3]  = '{0, 1'b0, 8'h50, 32'h0,         32'hCCCC_DDDD, 1'b0};
    tbl[4]  = '{0, 1'b0, 8'h10, 32'h0,         32'hAAAA_BBBB, 1'b0};
    tbl[5]  = '{1, 1'b1, 8'h30, 32'h1234_5678, 32'h0,         1'b1};
    tbl[6]  = '{1, 1'b0, 8'h30, 32'h0,         32'h0,         1'b1};
    tbl[7]  = '{1, 1'b0, 8'h1F, 32'h0,         32'h0,         1'b0};
    tbl[8]  = '{2, 1'b1, 8'h07, 32'h0BAD_F00D, 32'h0,         1'b0};
    tbl[9]  = '{2, 1'b0, 8'h07, 32'h0,         32'h0BAD_F00D, 1'b0};
    tbl[10] = '{1, 1'b1, 8'h1F, 32'h5A5A_5A5A, 32'h0,         1'b0};
    tbl[11] = '{1, 1'b0, 8'h1F, 32'h0,         32'h5A5A_5A5A, 1'b0};

    for (int b = 0; b < 3; b++) begin
      vld[b] = 1'b0; we[b] = 1'b0; ad[b] = 8'h0; wd[b] = 32'h0;
    end
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("reset_ready b%0d", b), 32'(rdy[b]), 32'd0);
      chk($sformatf("reset_rdata b%0d", b), rd[b], 32'h0);
      chk($sformatf("reset_resp b%0d", b), 32'(rs[b]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      xact(tbl[i].b, tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, ord, ors, lat);
      chk($sformatf("vec%0d rdata", i), ord, tbl[i].erd);
      chk($sformatf("vec%0d resp", i), 32'(ors), 32'(tbl[i].ers));
      chk($sformatf("vec%0d latency", i), lat, wl(tbl[i].b) + 1);
      model_apply(tbl[i].b, tbl[i].w, tbl[i].a, tbl[i].d);
    end

    // Address outside both bus-0 windows: nothing answers.
    @(negedge clk);
    vld[0] = 1'b1; we[0] = 1'b0; ad[0] = 8'h90;
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy[0] || rd[0] != 32'h0 || rs[0]) ok = 1'b0;
    end
    chk("unselected_silent", 32'(ok), 32'd1);
    @(negedge clk);
    vld[0] = 1'b0;

    // Abort during WAIT on the W=3 bus: valid low at N+1, no pulse, no write.
    @(negedge clk);
    vld[1] = 1'b1; we[1] = 1'b1; ad[1] = 8'h1F; wd[1] = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    vld[1] = 1'b0;
    ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy[1]) ok = 1'b0;
    end
    chk("abort_no_ready", 32'(ok), 32'd1);
    xact(1, 1'b0, 8'h1F, 32'h0, 1'b0, ord, ors, lat);
    chk("abort_kept_old", ord, 32'h5A5A_5A5A);

    // Back-to-back with valid held high: pulses spaced W+2 apart.
    for (int b = 0; b < 3; b += 2) begin
      xact(b, 1'b1, 8'h20, 32'h1111_0000 + 32'(b), 1'b1, ord, ors, lat);
      model_apply(b, 1'b1, 8'h20, 32'h1111_0000 + 32'(b));
      c1 = rdy_cyc;
      xact(b, 1'b1, 8'h21, 32'h2222_0000 + 32'(b), 1'b0, ord, ors, lat);
      model_apply(b, 1'b1, 8'h21, 32'h2222_0000 + 32'(b));
      chk($sformatf("b2b_spacing b%0d", b), rdy_cyc - c1, wl(b) + 2);
      xact(b, 1'b0, 8'h20, 32'h0, 1'b0, ord, ors, lat);
      chk($sformatf("b2b_word0 b%0d", b), ord, 32'h1111_0000 + 32'(b));
      xact(b, 1'b0, 8'h21, 32'h0, 1'b0, ord, ors, lat);
      chk($sformatf("b2b_word1 b%0d", b), ord, 32'h2222_0000 + 32'(b));
    end

    // Randomized traffic against the flat model.
    for (int i = 0; i < 150; i++) begin
      int          b;
      bit          w;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] erd;
      b   = int'($urandom_range(0, 2));
      w   = 1'($urandom_range(0, 1));
      a   = (b == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(0, 63));
      d   = $urandom;
      erd = model_rd(b, w, a);
      xact(b, w, a, d, 1'b0, ord, ors, lat);
      chk($sformatf("rnd%0d rdata b%0d a%h", i, b, a), ord, erd);
      chk($sformatf("rnd%0d resp", i), 32'(ors), 32'(model_err(b, a)));
      chk($sformatf("rnd%0d latency", i), lat, wl(b) + 1);
      model_apply(b, w, a, d);
    end

    // Reset asserted mid-WAIT: outputs drop at once, memory cleared.
    @(negedge clk);
    vld[0] = 1'b1; we[0] = 1'b1; ad[0] = 8'h05; wd[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'h0);
    chk("rst_resp", 32'(rs[0]), 32'd0);
    @(negedge clk);
    vld[0] = 1'b0;
    ok = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (rdy[0] || rdy[1] || rdy[2]) ok = 1'b0;
    end
    chk("rst_no_pulse", 32'(ok), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    xact(0, 1'b0, 8'h10, 32'h0, 1'b0, ord, ors, lat);
    chk("rst_cleared_0x10", ord, 32'h0);
    xact(0, 1'b0, 8'h50, 32'h0, 1'b0, ord, ors, lat);
    chk("rst_cleared_0x50", ord, 32'h0);
    xact(0, 1'b0, 8'h05, 32'h0, 1'b0, ord, ors, lat);
    chk("rst_no_partial_write", ord, 32'h0);
    xact(0, 1'b1, 8'h05, 32'h0505_0505, 1'b0, ord, ors, lat);
    chk("post_rst_write_resp", 32'(ors), 32'd0);
    xact(0, 1'b0, 8'h05, 32'h0, 1'b0, ord, ors, lat);
    chk("post_rst_read", ord, 32'h0505_0505);
    chk("post_rst_read_resp", 32'(ors), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
